// File: rtl/selector_config_loader.sv
// selector_config_loader
// Builds the selector word bank for data_selector. Entries are written one at
// a time into a shadow bank. A commit with a complete shadow bank copies it
// into the active bank in a single edge, with wBusy held high around the swap.
module selector_config_loader #(
  parameter int ENTRIES     = 16,
  parameter int ENTRY_WIDTH = 11,
  parameter int INDEX_WIDTH = 4,
  parameter int BUSY_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [INDEX_WIDTH-1:0]         cfg_index,
  input  logic [ENTRY_WIDTH-1:0]         cfg_entry,
  input  logic                           cfg_commit,
  output logic [ENTRIES*ENTRY_WIDTH-1:0] wSelec,
  output logic                           wBusy,
  output logic [ENTRIES-1:0]             loaded_mask,
  output logic                           cfg_error,
  output logic [7:0]                     commit_count
);

  localparam int BANK_W = ENTRIES * ENTRY_WIDTH;
  // HOLD lasts BUSY_CYCLES-1 cycles; the counter only has to hold that value.
  localparam int CNT_W  = (BUSY_CYCLES > 2) ? $clog2(BUSY_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SWAP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [BANK_W-1:0]    r_shadow;
  logic [BANK_W-1:0]    r_active;
  logic [ENTRIES-1:0]   r_mask;
  logic [CNT_W-1:0]     r_hold_cnt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_error;
  logic [7:0]           r_commits;

  logic                 w_idx_ok;
  logic [ENTRIES-1:0]   w_onehot;
  logic [ENTRIES-1:0]   w_mask_next;
  logic                 w_wr_req;
  logic                 w_wr_en;
  logic                 w_commit_ok;
  logic                 w_commit_bad;
  logic                 w_hold_done;
  logic                 w_ready_next;
  logic                 w_busy_next;
  logic                 w_error_next;

  // Decode the incoming write and evaluate a commit against the mask that
  // already includes a write accepted in the same cycle.
  always_comb begin
    w_idx_ok     = (32'(cfg_index) < 32'(ENTRIES));
    w_onehot     = w_idx_ok ? (ENTRIES'(1) << cfg_index) : '0;
    w_wr_req     = (r_state == S_IDLE) && r_ready && cfg_valid;
    w_mask_next  = r_mask | (w_wr_req ? w_onehot : '0);
    w_commit_ok  = (r_state == S_IDLE) && cfg_commit && (&w_mask_next);
    w_commit_bad = (r_state == S_IDLE) && cfg_commit && !(&w_mask_next);
    // A rejected commit leaves the shadow bank untouched, including a
    // write offered alongside it.
    w_wr_en      = w_wr_req && w_idx_ok && !w_commit_bad;
    w_hold_done  = (r_hold_cnt == CNT_W'(1));
  end

  // State register with the control registers that follow the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_mask     <= '0;
      r_commits  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_error <= w_error_next;
      if (r_state == S_SWAP) begin
        r_mask     <= '0;
        r_commits  <= r_commits + 8'd1;
        r_hold_cnt <= CNT_W'(BUSY_CYCLES - 1);
      end else begin
        if (w_wr_en) begin
          r_mask <= r_mask | w_onehot;
        end
        if (r_state == S_HOLD) begin
          r_hold_cnt <= r_hold_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Next-state logic: IDLE -> SWAP on a complete commit, one SWAP cycle,
  // then HOLD until the busy window has run out.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_commit_ok) w_state_next = S_SWAP;
      S_SWAP:  w_state_next = S_HOLD;
      S_HOLD:  if (w_hold_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered handshake/status outputs.
  always_comb begin
    w_ready_next = (w_state_next == S_IDLE);
    w_busy_next  = (w_state_next != S_IDLE);
    w_error_next = w_commit_bad || (w_wr_req && !w_idx_ok);
  end

  // Shadow and active banks; the active bank changes only at the SWAP edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_wr_en) begin
        r_shadow[int'(cfg_index)*ENTRY_WIDTH +: ENTRY_WIDTH] <= cfg_entry;
      end
      if (r_state == S_SWAP) begin
        r_active <= r_shadow;
      end
    end
  end

  assign cfg_ready    = r_ready;
  assign wBusy        = r_busy;
  assign wSelec       = r_active;
  assign loaded_mask  = r_mask;
  assign cfg_error    = r_error;
  assign commit_count = r_commits;

endmodule

// File: tb/tb_selector_config_loader.sv
// Self-checking bench for selector_config_loader: an abstract model of the
// bank contents and commit timeline, compared with the DUT every cycle, plus
// directed literal expectations for the main scenarios.
module tb_selector_config_loader;

  localparam int N    = 16;
  localparam int EW   = 11;
  localparam int BUSY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_commit = 1'b0;
  logic [3:0]        cfg_index = '0;
  logic [EW-1:0]     cfg_entry = '0;
  logic              cfg_ready;
  logic [N*EW-1:0]   wSelec;
  logic              wBusy;
  logic [N-1:0]      loaded_mask;
  logic              cfg_error;
  logic [7:0]        commit_count;

  selector_config_loader #(
    .ENTRIES(N), .ENTRY_WIDTH(EW), .INDEX_WIDTH(4), .BUSY_CYCLES(BUSY)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_index(cfg_index), .cfg_entry(cfg_entry),
    .cfg_commit(cfg_commit),
    .wSelec(wSelec), .wBusy(wBusy),
    .loaded_mask(loaded_mask), .cfg_error(cfg_error),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [N*EW-1:0] act, input logic [N*EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: bank contents as arrays, the commit as a count of edges elapsed
  // since it was accepted (0 = no commit in flight).
  logic [EW-1:0] m_shadow [N];
  logic [EW-1:0] m_active [N];
  logic [N-1:0]  m_mask;
  int            m_count;
  int            m_t;
  bit            m_ready;
  bit            m_err;

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_mask = '0; m_count = 0; m_t = 0; m_ready = 0; m_err = 0;
  endtask

  // One clock edge of the model, using the inputs that edge will sample.
  task automatic m_step();
    logic [N-1:0] bit_k;
    logic [N-1:0] nm;
    bit wr;
    m_err = 0;
    if (m_t != 0) begin
      m_t++;
      if (m_t == 2) begin
        for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
        m_mask  = '0;
        m_count = (m_count + 1) % 256;
      end
      if (m_t == BUSY + 1) m_t = 0;
    end else begin
      wr    = m_ready && cfg_valid;
      bit_k = 16'd1 << cfg_index;
      nm    = m_mask | (wr ? bit_k : 16'd0);
      if (cfg_commit && nm != 16'hFFFF) begin
        m_err = 1;
      end else begin
        if (wr) m_shadow[cfg_index] = cfg_entry;
        m_mask = nm;
        if (cfg_commit) m_t = 1;
      end
    end
    m_ready = (m_t == 0);
  endtask

  // Per-cycle compare at the falling edge; inputs change only just after the
  // rising edge, so what is seen here is what the next rising edge samples.
  always @(negedge clk) begin
    logic [N*EW-1:0] pack;
    if (rst) m_reset();
    pack = '0;
    for (int k = 0; k < N; k++) pack[k*EW +: EW] = m_active[k];
    chk("wSelec", wSelec, pack);
    chk("wBusy", wBusy, (m_t != 0));
    chk("cfg_ready", cfg_ready, m_ready);
    chk("loaded_mask", loaded_mask, m_mask);
    chk("cfg_error", cfg_error, m_err);
    chk("commit_count", commit_count, m_count[7:0]);
    if (!rst) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int idx, input logic [EW-1:0] val);
    cfg_valid = 1'b1;
    cfg_index = idx[3:0];
    cfg_entry = val;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_all(input int upto);
    for (int k = 0; k <= upto; k++) wr(k, 11'($urandom));
  endtask

  initial begin
    logic [N*EW-1:0] saved;
    logic [EW-1:0]   v3;
    int nb;

    // Reset then idle
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", wBusy, 1'b0);
    chk("rst_wselec", wSelec, '0);
    chk("rst_mask", loaded_mask, '0);
    rst = 1'b0;
    chk("rel_ready_low", cfg_ready, 1'b0);
    tick();
    chk("rel_ready_high", cfg_ready, 1'b1);

    // Full load and commit
    for (int k = 0; k < N; k++) begin
      logic [3:0] kk;
      kk = k[3:0];
      wr(k, {6'b100110, kk, 1'b0});
    end
    chk("full_mask", loaded_mask, 16'hFFFF);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    nb = 0;
    while (wBusy && nb < 10) begin
      nb++;
      tick();
    end
    chk("busy_len", 32'(nb), 32'(BUSY));
    chk("entry1", wSelec[21:11], 11'b100110_0001_0);
    chk("entry15", wSelec[175:165], 11'b100110_1111_0);
    chk("full_mask_clr", loaded_mask, '0);
    chk("count1", commit_count, 8'd1);
    chk("ready_back", cfg_ready, 1'b1);

    // Partial commit is rejected
    saved = wSelec;
    load_all(14);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("part_err", cfg_error, 1'b1);
    chk("part_busy", wBusy, 1'b0);
    chk("part_mask", loaded_mask, 16'h7FFF);
    chk("part_wselec", wSelec, saved);
    tick();
    chk("part_err_pulse", cfg_error, 1'b0);

    // Write of the last entry in the same cycle as the commit
    load_all(14);
    cfg_valid = 1'b1; cfg_index = 4'd15; cfg_entry = 11'h7FF; cfg_commit = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    chk("same_busy", wBusy, 1'b1);
    tick();
    tick();
    chk("same_e15", wSelec[175:165], 11'h7FF);
    chk("same_count", commit_count, 8'd2);

    // Writes offered while busy are ignored
    load_all(15);
    v3 = 11'h2A5;
    wr(3, v3);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_valid = 1'b1; cfg_index = 4'd3; cfg_entry = 11'h15A;
    chk("busyw_ready0", cfg_ready, 1'b0);
    tick();
    chk("busyw_ready1", cfg_ready, 1'b0);
    tick();
    cfg_valid = 1'b0;
    chk("busyw_mask", loaded_mask, '0);
    chk("busyw_e3", wSelec[43:33], v3);
    chk("busyw_count", commit_count, 8'd3);

    // Reset during SWAP aborts the commit
    load_all(15);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("abort_in_swap", wBusy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_wselec", wSelec, '0);
    chk("abort_busy", wBusy, 1'b0);
    chk("abort_count", commit_count, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cfg_valid  = ($urandom_range(0, 3) != 0);
      cfg_index  = 4'($urandom);
      cfg_entry  = 11'($urandom);
      cfg_commit = ($urandom_range(0, 19) == 0);
      tick();
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
